mix_columns_seq: RTL
====================

// Module: mix_columns_seq
// PURPOSE
//  Sequential, parametrised AES MixColumns engine: forward, inverse or bypass on a
//  128-bit state. Processes COLS_PER_CYCLE columns per clock behind valid/ready
//  handshakes. Sits between ShiftRows and AddRoundKey in the shared AES round datapath.
//  Bypass covers the final round. Inverse mode covers the decryption path.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per clock; legal 1, 2, 4 (others: elaboration error)
// PORTS
//  clk        in   1    system clock, all state on rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    state_in/mode valid
//  in_ready   out  1    engine can accept a state this cycle
//  mode       in   2    00 fwd, 01 inv, 10 bypass, 11 reserved = bypass
//  state_in   in   128  column c = bits[127-32c -: 32], row 0 in the MS byte of each column
//  out_valid  out  1    state_out holds a finished result
//  out_ready  in   1    downstream accepts result
//  state_out  out  128  transformed state, same byte layout as state_in
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM=IDLE, col counter=0, data reg=0, mode reg=00,
//    out_valid=0, state_out=0. in_ready goes 1 once in IDLE after reset release.
//  - NCYC = 4/COLS_PER_CYCLE.
//  - FSM IDLE: in_ready=1. in_valid&in_ready: latch state_in and mode, col=0, -> BUSY.
//  - FSM BUSY: each cycle transforms columns col..col+COLS_PER_CYCLE-1 in place, then
//    col += COLS_PER_CYCLE.
//    After the NCYC-th cycle, col wraps to 0 and FSM -> DONE.
//  - Bypass mode also spends NCYC cycles, so latency is mode-independent.
//  - FSM DONE: out_valid=1, state_out stable until out_valid&out_ready.
//  - Latency: out_valid rises NCYC cycles after the accept edge (COLS_PER_CYCLE=4 gives 1).
//  - in_ready = IDLE | (DONE & out_ready).
//  - Simultaneous handoff: out handshake and in handshake in the same cycle send DONE
//    directly to BUSY with the new state. No bubble, no loss.
//    Sustained throughput is therefore one state per NCYC+1 cycles.
//  - DONE & out_ready & !in_valid -> IDLE. out_valid drops next cycle.
//  - in_valid while busy is ignored (in_ready=0). Upstream holds data.
//  - mode and state_in are sampled only at accept; later changes have no effect.
//  - Reset asserted mid-operation discards the in-flight state with no partial output.
//  - Arithmetic: GF(2^8) mod x^8+x^4+x^3+x+1. xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0).
//  - Forward matrix rows {02 03 01 01} rotated. Inverse rows {0e 0b 0d 09} rotated.
//    All byte results are 8 bits, no carries.
// STRUCTURE
//  - Shared package aes_pkg: MODE_FWD/MODE_INV/MODE_BYP localparams, AES_POLY=8'h1b,
//    xtime and gmul helper functions, state/column typedefs.
//  - Sub-module mix_column_word: combinational 32-bit in, 32-bit out, mode in.
//  - Top instantiates COLS_PER_CYCLE mix_column_word copies.
//  - A column mux is selected by col. Holds FSM, counter and data register.
// TESTING
//  - FIPS-197 round 1, fwd, COLS_PER_CYCLE=1: d4bf5d30e0b452aeb84111f11e2798e5 ->
//    046681e5e0cb199a48f8d37a2806264c.
//    out_valid exactly 4 cycles after accept.
//  - Inverse of the previous output, mode=01: 046681e5e0cb199a48f8d37a2806264c ->
//    d4bf5d30e0b452aeb84111f11e2798e5.
//    Repeat with COLS_PER_CYCLE=2 (latency 2) and COLS_PER_CYCLE=4 (latency 1).
//  - Column vectors fwd: db135345 -> 8e4da1bc, f20a225c -> 9fdc589d,
//    01010101 -> 01010101, c6c6c6c6 -> c6c6c6c6 (one per column slot).
//  - Bypass mode=10 and mode=11: any state returns unchanged after NCYC cycles.
//  - Backpressure: hold out_ready=0 for 10 cycles. state_out stays stable and in_ready=0.
//    Then assert out_ready together with in_valid carrying a new state.
//    The new state is accepted the same cycle and its result arrives NCYC cycles later.
//  - Async reset pulsed mid-BUSY (col=2): out_valid=0 and state_out=0 immediately, no
//    stale output. A fresh accept afterwards yields correct results.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: mode encodings, GF(2^8) helpers and state/column types.
package aes_pkg;

    localparam logic [1:0] MODE_FWD = 2'b00;
    localparam logic [1:0] MODE_INV = 2'b01;
    localparam logic [1:0] MODE_BYP = 2'b10;
    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [31:0]  col_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // MixColumns coefficients never exceed 4 bits, so only 4 doublings are needed.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int unsigned i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_columns_seq_word.sv
// Combinational single-column MixColumns: forward, inverse or pass-through.
module mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic [1:0]  mode,
    output logic [31:0] col_out
);

    logic [7:0] a    [4];
    logic [3:0] coef [4];

    always_comb begin
        for (int unsigned r = 0; r < 4; r++) a[r] = col_in[31-8*r -: 8];
    end

    always_comb begin
        if (mode == MODE_INV) coef = '{4'he, 4'hb, 4'hd, 4'h9};
        else                  coef = '{4'h2, 4'h3, 4'h1, 4'h1};
    end

    // Row r uses the base coefficient row rotated right by r.
    always_comb begin
        logic [7:0] acc;
        logic [1:0] idx;
        col_out = col_in;
        acc     = '0;
        idx     = '0;
        case (mode)
            MODE_FWD, MODE_INV: begin
                for (int unsigned r = 0; r < 4; r++) begin
                    acc = '0;
                    for (int unsigned k = 0; k < 4; k++) begin
                        idx = 2'(k - r);
                        acc = acc ^ gmul(a[k], coef[idx]);
                    end
                    col_out[31-8*r -: 8] = acc;
                end
            end
            MODE_BYP: col_out = col_in;
            default:  col_out = col_in;
        endcase
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns engine: COLS_PER_CYCLE columns per clock behind valid/ready.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // A 2-bit column counter wraps to 0 on its own after the last group.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

    fsm_t       fsm_q, fsm_d;
    logic [1:0] col_q, col_d;
    state_t     data_q, data_d;
    logic [1:0] mode_q, mode_d;

    col_t word_in  [COLS_PER_CYCLE];
    col_t word_out [COLS_PER_CYCLE];

    always_comb begin
        logic [1:0] rd_slot;
        rd_slot = '0;
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
            rd_slot    = col_q + 2'(j);
            word_in[j] = data_q[127-32*rd_slot -: 32];
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_word
        mix_column_word u_word (
            .col_in  (word_in[g]),
            .mode    (mode_q),
            .col_out (word_out[g])
        );
    end

    always_comb begin
        logic [1:0] wr_slot;
        wr_slot   = '0;
        fsm_d     = fsm_q;
        col_d     = col_q;
        data_d    = data_q;
        mode_d    = mode_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d = state_in;
                    mode_d = mode;
                    col_d  = '0;
                    fsm_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
                    wr_slot = col_q + 2'(j);
                    data_d[127-32*wr_slot -: 32] = word_out[j];
                end
                col_d = col_q + COL_STEP;
                if (col_q == COL_LAST) fsm_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        data_d = state_in;
                        mode_d = mode;
                        col_d  = '0;
                        fsm_d  = ST_BUSY;
                    end else begin
                        fsm_d = ST_IDLE;
                    end
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= ST_IDLE;
            col_q  <= '0;
            data_q <= '0;
            mode_q <= MODE_FWD;
        end else begin
            fsm_q  <= fsm_d;
            col_q  <= col_d;
            data_q <= data_d;
            mode_q <= mode_d;
        end
    end

    assign state_out = data_q;

endmodule
